mcu: RTL and testbench

MCU -- requirements
Module: mcu

---
 rtl/mcu_if.sv | 26 ++
 rtl/mcu.sv | 113 +++++++++++
 tb/tb_mcu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mcu_if.sv
// rtl/mcu_if.sv - instruction in / decoded control out bundle for the mcu decoder
interface mcu_if;
    logic [31:0] inst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic [1:0]  alu_op;
    logic [3:0]  alu_ctrl;
    logic [31:0] imm;
    logic        illegal;

    modport master (
        output inst,
        input  alu_src, mem_to_reg, reg_write, mem_read, mem_write,
        input  branch, alu_op, alu_ctrl, imm, illegal
    );

    modport slave (
        input  inst,
        output alu_src, mem_to_reg, reg_write, mem_read, mem_write,
        output branch, alu_op, alu_ctrl, imm, illegal
    );
endinterface

// File: rtl/mcu.sv
// rtl/mcu.sv - registered RV32I main/ALU control decoder with immediate generation
module mcu (
    input  logic  clk,
    input  logic  rst,
    mcu_if.slave  bus
);
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7b;

    logic        n_alu_src;
    logic        n_mem_to_reg;
    logic        n_reg_write;
    logic        n_mem_read;
    logic        n_mem_write;
    logic        n_branch;
    logic [1:0]  n_alu_op;
    logic [3:0]  n_alu_ctrl;
    logic [31:0] n_imm;
    logic        n_illegal;

    assign opcode = bus.inst[6:0];
    assign funct3 = bus.inst[14:12];
    assign f7b    = bus.inst[30];

    // Decode the current instruction; anything unsupported collapses to illegal with all else zero.
    always_comb begin
        n_alu_src    = 1'b0;
        n_mem_to_reg = 1'b0;
        n_reg_write  = 1'b0;
        n_mem_read   = 1'b0;
        n_mem_write  = 1'b0;
        n_branch     = 1'b0;
        n_alu_op     = 2'b00;
        n_alu_ctrl   = 4'b0000;
        n_imm        = 32'd0;
        n_illegal    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case ({f7b, funct3})
                    4'b0_000: n_alu_ctrl = CTRL_ADD;
                    4'b1_000: n_alu_ctrl = CTRL_SUB;
                    4'b0_111: n_alu_ctrl = CTRL_AND;
                    4'b0_110: n_alu_ctrl = CTRL_OR;
                    default:  n_illegal  = 1'b1;
                endcase
                if (!n_illegal) begin
                    n_reg_write = 1'b1;
                    n_alu_op    = 2'b10;
                end
            end
            OP_LOAD: begin
                n_alu_src    = 1'b1;
                n_mem_to_reg = 1'b1;
                n_reg_write  = 1'b1;
                n_mem_read   = 1'b1;
                n_alu_ctrl   = CTRL_ADD;
                n_imm        = {{20{bus.inst[31]}}, bus.inst[31:20]};
            end
            OP_STORE: begin
                n_alu_src   = 1'b1;
                n_mem_write = 1'b1;
                n_alu_ctrl  = CTRL_ADD;
                n_imm       = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
            end
            OP_BRANCH: begin
                n_branch   = 1'b1;
                n_alu_op   = 2'b01;
                n_alu_ctrl = CTRL_SUB;
                n_imm      = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                              bus.inst[30:25], bus.inst[11:8], 1'b0};
            end
            default: n_illegal = 1'b1;
        endcase
    end

    // Register every decoded output; reset clears them without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.alu_src    <= 1'b0;
            bus.mem_to_reg <= 1'b0;
            bus.reg_write  <= 1'b0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
            bus.branch     <= 1'b0;
            bus.alu_op     <= 2'b00;
            bus.alu_ctrl   <= 4'b0000;
            bus.imm        <= 32'd0;
            bus.illegal    <= 1'b0;
        end else begin
            bus.alu_src    <= n_alu_src;
            bus.mem_to_reg <= n_mem_to_reg;
            bus.reg_write  <= n_reg_write;
            bus.mem_read   <= n_mem_read;
            bus.mem_write  <= n_mem_write;
            bus.branch     <= n_branch;
            bus.alu_op     <= n_alu_op;
            bus.alu_ctrl   <= n_alu_ctrl;
            bus.imm        <= n_imm;
            bus.illegal    <= n_illegal;
        end
    end
endmodule

// File: tb/tb_mcu.sv
// tb/tb_mcu.sv - directed self-checking bench for the mcu decoder
module tb_mcu;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    mcu_if bus ();

    mcu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, alu_ctrl, imm, illegal}
    function automatic logic [44:0] outs();
        return {bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read, bus.mem_write,
                bus.branch, bus.alu_op, bus.alu_ctrl, bus.imm, bus.illegal};
    endfunction

    function automatic logic [44:0] pk(input logic as, input logic mtr, input logic rw,
                                       input logic mr, input logic mw, input logic br,
                                       input logic [1:0] aop, input logic [3:0] actl,
                                       input logic [31:0] im, input logic ill);
        return {as, mtr, rw, mr, mw, br, aop, actl, im, ill};
    endfunction

    localparam logic [44:0] ZERO = 45'd0;
    localparam logic [44:0] ILL  = 45'd1;

    task automatic apply(input logic [31:0] i);
        @(negedge clk);
        bus.inst = i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [44:0] e;
        rst = 1'b0;
        bus.inst = 32'h0000_0063;
        #1 rst = 1'b1;
        #2;
        compared++;
        if (outs() !== ZERO) begin
            mismatched++;
            $display("FAIL reset_before_edge got=%h exp=%h", outs(), ZERO);
        end
        @(posedge clk);
        #1;
        compared++;
        if (outs() !== ZERO) begin
            mismatched++;
            $display("FAIL reset_held_over_edge got=%h exp=%h", outs(), ZERO);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        e = pk(0, 0, 0, 0, 0, 1, 2'b01, 4'b0110, 32'h0, 0);
        compared++;
        if (outs() !== e) begin
            mismatched++;
            $display("FAIL reset_first_decode got=%h exp=%h", outs(), e);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] ins [4];
        logic [44:0] exp [4];
        ins[0] = 32'h0000_0063; exp[0] = pk(0, 0, 0, 0, 0, 1, 2'b01, 4'b0110, 32'h0, 0);
        ins[1] = 32'h0000_0023; exp[1] = pk(1, 0, 0, 0, 1, 0, 2'b00, 4'b0010, 32'h0, 0);
        ins[2] = 32'h0000_0033; exp[2] = pk(0, 0, 1, 0, 0, 0, 2'b10, 4'b0010, 32'h0, 0);
        ins[3] = 32'h0000_0003; exp[3] = pk(1, 1, 1, 1, 0, 0, 2'b00, 4'b0010, 32'h0, 0);
        for (int k = 0; k < 4; k++) begin
            apply(ins[k]);
            compared++;
            if (outs() !== exp[k]) begin
                mismatched++;
                $display("FAIL seq[%0d] inst=%h got=%h exp=%h", k, ins[k], outs(), exp[k]);
            end
        end
    endtask

    task automatic test_rtype();
        logic [31:0] ins [6];
        logic [44:0] exp [6];
        ins[0] = 32'h4000_0033; exp[0] = pk(0, 0, 1, 0, 0, 0, 2'b10, 4'b0110, 32'h0, 0);
        ins[1] = 32'h0000_7033; exp[1] = pk(0, 0, 1, 0, 0, 0, 2'b10, 4'b0000, 32'h0, 0);
        ins[2] = 32'h0000_6033; exp[2] = pk(0, 0, 1, 0, 0, 0, 2'b10, 4'b0001, 32'h0, 0);
        ins[3] = 32'h0000_1033; exp[3] = ILL;
        ins[4] = 32'h4000_7033; exp[4] = ILL;
        ins[5] = 32'h00B5_0533; exp[5] = pk(0, 0, 1, 0, 0, 0, 2'b10, 4'b0010, 32'h0, 0);
        for (int k = 0; k < 6; k++) begin
            apply(ins[k]);
            compared++;
            if (outs() !== exp[k]) begin
                mismatched++;
                $display("FAIL rtype[%0d] inst=%h got=%h exp=%h", k, ins[k], outs(), exp[k]);
            end
        end
    endtask

    task automatic test_imm();
        logic [31:0] ins [4];
        logic [44:0] exp [4];
        ins[0] = 32'hFFC1_2083; exp[0] = pk(1, 1, 1, 1, 0, 0, 2'b00, 4'b0010, 32'hFFFF_FFFC, 0);
        ins[1] = 32'hFE11_2E23; exp[1] = pk(1, 0, 0, 0, 1, 0, 2'b00, 4'b0010, 32'hFFFF_FFFC, 0);
        ins[2] = 32'hFE00_0EE3; exp[2] = pk(0, 0, 0, 0, 0, 1, 2'b01, 4'b0110, 32'hFFFF_FFFC, 0);
        ins[3] = 32'h7E00_0763; exp[3] = pk(0, 0, 0, 0, 0, 1, 2'b01, 4'b0110, 32'h0000_07EE, 0);
        for (int k = 0; k < 4; k++) begin
            apply(ins[k]);
            compared++;
            if (outs() !== exp[k]) begin
                mismatched++;
                $display("FAIL imm[%0d] inst=%h got=%h exp=%h", k, ins[k], outs(), exp[k]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [44:0] e;
        apply(32'h0000_007F);
        compared++;
        if (outs() !== ILL) begin
            mismatched++;
            $display("FAIL illegal_7f got=%h exp=%h", outs(), ILL);
        end
        apply(32'h0000_0033);
        e = pk(0, 0, 1, 0, 0, 0, 2'b10, 4'b0010, 32'h0, 0);
        compared++;
        if (outs() !== e) begin
            mismatched++;
            $display("FAIL illegal_recover got=%h exp=%h", outs(), e);
        end
        apply(32'hFFF0_0013);
        compared++;
        if (outs() !== ILL) begin
            mismatched++;
            $display("FAIL illegal_itype got=%h exp=%h", outs(), ILL);
        end
    endtask

    task automatic test_async_reset();
        apply(32'h0000_0033);
        compared++;
        if (bus.reg_write !== 1'b1) begin
            mismatched++;
            $display("FAIL async_pre reg_write got=%b exp=1", bus.reg_write);
        end
        #2 rst = 1'b1;
        #1;
        compared++;
        if (outs() !== ZERO) begin
            mismatched++;
            $display("FAIL async_mid_cycle got=%h exp=%h", outs(), ZERO);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.inst = 32'h0000_0003;
        @(posedge clk);
        #1;
        compared++;
        if (outs() !== pk(1, 1, 1, 1, 0, 0, 2'b00, 4'b0010, 32'h0, 0)) begin
            mismatched++;
            $display("FAIL async_release got=%h exp=%h", outs(),
                     pk(1, 1, 1, 1, 0, 0, 2'b00, 4'b0010, 32'h0, 0));
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_sequence();
        test_rtype();
        test_imm();
        test_illegal();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
